// File: rtl/imem_boot_pkg.sv
// Shared encodings for the instruction-memory boot controller.
package imem_boot_pkg;

    localparam int unsigned STATUS_W = 3;

    typedef enum logic [STATUS_W-1:0] {
        ST_LOAD    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_HANG    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    // MIPS syscall encoding used as the end-of-program marker
    localparam logic [31:0] HALT_IR_DEFAULT = 32'h0000000C;

    function automatic logic is_terminal(input state_t s);
        return (s == ST_DONE) || (s == ST_HANG) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/pc_stall_detect.sv
// Flags a hang when the CPU PC has stayed unchanged for STALL_LIMIT cycles.
module pc_stall_detect #(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_hang_c
);

    localparam int unsigned CNT_W = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;

    logic [PC_W-1:0]  r_last_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             w_same;

    assign w_same   = (i_pc == r_last_pc);
    // This cycle's repeat brings the count of unchanged cycles to STALL_LIMIT-1
    assign o_hang_c = i_en && w_same && (r_cnt == CNT_W'(STALL_LIMIT - 2));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_last_pc <= '0;
            r_cnt     <= '0;
        end else if (i_en) begin
            r_last_pc <= i_pc;
            r_cnt     <= w_same ? r_cnt + CNT_W'(1) : '0;
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Loads a program into imem, holds the CPU in reset, runs it and watches for halt/hang/timeout.
module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 10,
    parameter int unsigned       RST_CYCLES  = 4,
    parameter logic [DATA_W-1:0] HALT_IR     = DATA_W'(HALT_IR_DEFAULT),
    parameter int unsigned       STALL_LIMIT = 64,
    parameter int unsigned       CYC_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    input  logic [DATA_W-1:0]   load_data,
    input  logic                load_last,
    output logic                load_ready,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [DATA_W-1:0]   imem_wdata,
    output logic                cpu_rst,
    input  logic [31:0]         pc_in,
    input  logic [DATA_W-1:0]   ir_in,
    input  logic                restart,
    output logic [STATUS_W-1:0] status,
    output logic                overflow,
    output logic [ADDR_W:0]     words_loaded,
    output logic [CYC_W-1:0]    run_cycles
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned WCNT_W = ADDR_W + 1;
    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_hs;
    logic                w_at_end;
    logic                w_hang;
    logic [WCNT_W-1:0]   r_words;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [CYC_W-1:0]    r_run_cycles;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_cpu_rst;
    logic                r_ovf;

    assign load_ready = (r_state == ST_LOAD);
    assign w_hs       = load_valid && load_ready;
    assign w_at_end   = (r_words == WCNT_W'(DEPTH - 1));

    pc_stall_detect #(
        .PC_W        (32),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (r_state == ST_HOLD),
        .i_en     (r_state == ST_RUN),
        .i_pc     (pc_in),
        .o_hang_c (w_hang)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_hs && (load_last || w_at_end)) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ir_in == HALT_IR) begin
                    w_state_nxt = ST_DONE;
                end else if (w_hang) begin
                    w_state_nxt = ST_HANG;
                end else if (&r_run_cycles) begin
                    w_state_nxt = ST_TIMEOUT;
                end
            end
            default: begin
                // Terminal states wait for restart; unused encodings fall back to LOAD
                if (is_terminal(r_state)) begin
                    w_state_nxt = restart ? ST_HOLD : r_state;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
        endcase
    end

    // Load path: one registered cycle from handshake to imem write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_words <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_we <= w_hs;
            if (w_hs) begin
                r_addr  <= r_words[ADDR_W-1:0];
                r_wdata <= load_data;
                r_words <= r_words + WCNT_W'(1);
                if (w_at_end && !load_last) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt   <= '0;
            r_run_cycles <= '0;
            r_cpu_rst    <= 1'b1;
        end else begin
            r_cpu_rst  <= (w_state_nxt != ST_RUN);
            r_hold_cnt <= (r_state == ST_HOLD) ? r_hold_cnt + HOLD_W'(1) : '0;
            if (r_state == ST_RUN) begin
                if (!(&r_run_cycles)) begin
                    r_run_cycles <= r_run_cycles + CYC_W'(1);
                end
            end else if (w_state_nxt == ST_HOLD) begin
                r_run_cycles <= '0;
            end
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign cpu_rst      = r_cpu_rst;
    assign status       = r_state;
    assign overflow     = r_ovf;
    assign words_loaded = r_words;
    assign run_cycles   = r_run_cycles;

endmodule
